// File: rtl/tb_uart_bfm.sv
`timescale 1ns/1ps
// tb_uart_bfm: 8N1 UART transceiver used as a bench-side companion to the
// SoC user UART. TX serialises a byte when tx_start rises. RX deserialises
// frames arriving on ser_rx and strobes each byte out.
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   ser_rx / ser_tx       - serial lines, idle high
//   tx_start, tx_data     - launch request (rising edge) and byte to send
//   tx_busy, tx_clear_req - frame in flight / one-cycle completion pulse
//   rx_data               - last good byte
//   rx_valid, rx_frame_err - one-cycle strobes for good / bad-stop frames
module tb_uart_bfm #(
   parameter int CLKS_PER_BIT = 347,
   parameter int DATA_BITS    = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ser_rx,
   output logic       ser_tx,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_clear_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------- transmitter ----------------
   state_t          r_tx_state;
   state_t          w_tx_next;
   logic [CW-1:0]   r_tx_cnt;
   logic [2:0]      r_tx_idx;
   logic [7:0]      r_tx_data;
   logic            r_tx_start_d;
   logic            r_tx_clear;
   logic            w_tx_edge;
   logic            w_tx_bit_end;
   logic            w_tx_launch;
   logic            w_tx_done;

   assign w_tx_edge    = tx_start & ~r_tx_start_d;
   assign w_tx_bit_end = (r_tx_cnt == BIT_END);
   assign tx_busy      = (r_tx_state != S_IDLE);
   assign tx_clear_req = r_tx_clear;

   always_comb begin
      w_tx_next   = r_tx_state;
      w_tx_launch = 1'b0;
      w_tx_done   = 1'b0;
      ser_tx      = 1'b1;
      case (r_tx_state)
         S_IDLE: begin
            // Edges are only honoured here, so edges while busy are dropped.
            if (w_tx_edge) begin
               w_tx_launch = 1'b1;
               w_tx_next   = S_START;
            end
         end
         S_START: begin
            ser_tx = 1'b0;
            if (w_tx_bit_end) w_tx_next = S_DATA;
         end
         S_DATA: begin
            ser_tx = r_tx_data[r_tx_idx];
            if (w_tx_bit_end && r_tx_idx == LAST_IDX) w_tx_next = S_STOP;
         end
         S_STOP: begin
            if (w_tx_bit_end) begin
               w_tx_done = 1'b1;
               w_tx_next = S_IDLE;
            end
         end
         default: w_tx_next = S_IDLE;
      endcase
   end

   // The completion pulse is registered so it lands in the first IDLE
   // cycle, the same cycle tx_busy drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tx_state   <= S_IDLE;
         r_tx_cnt     <= '0;
         r_tx_idx     <= '0;
         r_tx_data    <= '0;
         r_tx_start_d <= 1'b0;
         r_tx_clear   <= 1'b0;
      end else begin
         r_tx_state   <= w_tx_next;
         r_tx_start_d <= tx_start;
         r_tx_clear   <= w_tx_done;
         if (w_tx_launch) r_tx_data <= tx_data;
         if (r_tx_state == S_IDLE || w_tx_bit_end) r_tx_cnt <= '0;
         else r_tx_cnt <= r_tx_cnt + 1'b1;
         if (r_tx_state != S_DATA) r_tx_idx <= '0;
         else if (w_tx_bit_end) r_tx_idx <= r_tx_idx + 3'd1;
      end
   end

   // ---------------- receiver ----------------
   state_t          r_rx_state;
   state_t          w_rx_next;
   logic            r_rx_s1;
   logic            r_rx_s2;
   logic [CW-1:0]   r_rx_cnt;
   logic [2:0]      r_rx_idx;
   logic [7:0]      r_rx_shift;
   logic [7:0]      r_rx_data;
   logic            r_rx_valid;
   logic            r_rx_err;
   logic            w_rx_sample;
   logic            w_rx_good;
   logic            w_rx_bad;
   logic            w_rx_cnt_clr;

   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign rx_frame_err = r_rx_err;

   // After the half-bit wait in START, every later sample falls mid-bit.
   always_comb begin
      w_rx_next    = r_rx_state;
      w_rx_sample  = 1'b0;
      w_rx_good    = 1'b0;
      w_rx_bad     = 1'b0;
      w_rx_cnt_clr = 1'b0;
      case (r_rx_state)
         S_IDLE: begin
            if (!r_rx_s2) w_rx_next = S_START;
         end
         S_START: begin
            if (r_rx_cnt == HALF_END) begin
               w_rx_cnt_clr = 1'b1;
               w_rx_next    = r_rx_s2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_rx_cnt == BIT_END) begin
               w_rx_cnt_clr = 1'b1;
               w_rx_sample  = 1'b1;
               if (r_rx_idx == LAST_IDX) w_rx_next = S_STOP;
            end
         end
         S_STOP: begin
            if (r_rx_cnt == BIT_END) begin
               w_rx_cnt_clr = 1'b1;
               w_rx_next    = S_IDLE;
               if (r_rx_s2) w_rx_good = 1'b1;
               else         w_rx_bad  = 1'b1;
            end
         end
         default: w_rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
      end else begin
         r_rx_s1    <= ser_rx;
         r_rx_s2    <= r_rx_s1;
         r_rx_state <= w_rx_next;
         r_rx_valid <= w_rx_good;
         r_rx_err   <= w_rx_bad;
         if (w_rx_good) r_rx_data <= r_rx_shift;
         if (w_rx_sample) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
         if (r_rx_state == S_IDLE || w_rx_cnt_clr) r_rx_cnt <= '0;
         else r_rx_cnt <= r_rx_cnt + 1'b1;
         if (r_rx_state != S_DATA) r_rx_idx <= '0;
         else if (w_rx_sample) r_rx_idx <= r_rx_idx + 3'd1;
      end
   end

endmodule

// File: tb/tb_tb_uart_bfm.sv
`timescale 1ns/1ps
// Self-checking bench for tb_uart_bfm: table-driven TX and RX frame
// vectors plus hand-written reset, idle and glitch sequences.
module tb_tb_uart_bfm;

   localparam int CPB = 347;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ser_rx = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       ser_tx;
   logic       tx_busy;
   logic       tx_clear_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;

   tb_uart_bfm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .ser_rx       (ser_rx),
      .ser_tx       (ser_tx),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .tx_clear_req (tx_clear_req),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err)
   );

   always #12.5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         n_valid = 0;
   int         n_ferr  = 0;
   int         n_clr   = 0;
   logic [7:0] last_rx = 8'h00;
   always @(negedge clock) begin
      if (rx_valid) begin
         n_valid++;
         last_rx = rx_data;
      end
      if (rx_frame_err) n_ferr++;
      if (tx_clear_req) n_clr++;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // f[i] is the i-th bit on the line: start, d0..d7, stop.
   typedef struct {
      logic [7:0] d;
      logic [9:0] f;
      bit         poke;
      bit         hold;
   } tx_vec_t;

   typedef struct {
      bit         glitch;
      logic [7:0] b;
      logic       stop;
      int         ev;
      int         ee;
      logic [7:0] ed;
   } rx_vec_t;

   // Launch on the next posedge, then sample each bit at its middle.
   // With poke set, tx_start is re-pulsed and tx_data scrambled mid-frame.
   task automatic tx_frame(input logic [7:0] d, input logic [9:0] f,
                           input bit poke);
      int   t0;
      int   t1;
      int   k;
      logic busy_ok;
      @(negedge clock);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock);
      t0      = cyc;
      busy_ok = tx_busy;
      @(negedge clock);
      busy_ok = busy_ok | tx_busy;
      chk($sformatf("tx_%02h_busy_rise", d), busy_ok, 1);
      repeat (CPB / 2 - 1) @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            for (int j = 0; j < CPB; j++) begin
               if (poke && i == 4 && j == 10) tx_start = 1'b0;
               if (poke && i == 4 && j == 20) begin
                  tx_start = 1'b1;
                  tx_data  = ~d;
               end
               @(negedge clock);
            end
         end
         chk($sformatf("tx_%02h_bit%0d", d, i), ser_tx, f[i]);
      end
      k = 0;
      while (tx_busy === 1'b1 && k < 500) begin
         @(negedge clock);
         k++;
      end
      chk($sformatf("tx_%02h_busy_fall", d), tx_busy, 0);
      t1 = cyc;
      chk($sformatf("tx_%02h_busy_len_%0d", d, t1 - t0),
          ((t1 - t0) >= 10 * CPB - 1) && ((t1 - t0) <= 10 * CPB + 1), 1);
      chk($sformatf("tx_%02h_clear_pulse", d), tx_clear_req, 1);
      @(negedge clock);
      chk($sformatf("tx_%02h_clear_one_cycle", d), tx_clear_req, 0);
   endtask

   // stop_len shorter than a bit keeps a low stop bit from reading as a
   // fresh start bit once the receiver returns to idle.
   task automatic rx_frame(input logic [7:0] b, input logic stop,
                           input int stop_len);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         ser_rx = fr[i];
         repeat ((i == 9) ? stop_len : CPB) @(negedge clock);
      end
      ser_rx = 1'b1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   tx_vec_t tx_tab[2];
   rx_vec_t rx_tab[4];

   initial begin
      int viol;
      int v0;
      int e0;
      int c0;

      tx_tab[0] = '{d: 8'h0F, f: 10'b1000011110, poke: 1'b1, hold: 1'b1};
      tx_tab[1] = '{d: 8'h3D, f: 10'b1001111010, poke: 1'b0, hold: 1'b0};

      rx_tab[0] = '{glitch: 1'b0, b: 8'h41, stop: 1'b1,
                    ev: 1, ee: 0, ed: 8'h41};
      rx_tab[1] = '{glitch: 1'b0, b: 8'h0A, stop: 1'b1,
                    ev: 1, ee: 0, ed: 8'h0A};
      rx_tab[2] = '{glitch: 1'b1, b: 8'h00, stop: 1'b1,
                    ev: 0, ee: 0, ed: 8'h0A};
      rx_tab[3] = '{glitch: 1'b0, b: 8'h55, stop: 1'b0,
                    ev: 0, ee: 1, ed: 8'h0A};

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_ser_tx", ser_tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_tx_clear_req", tx_clear_req, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_frame_err", rx_frame_err, 0);
      reset = 1'b0;

      // idle
      viol = 0;
      repeat (1000) begin
         @(negedge clock);
         if (ser_tx !== 1'b1 || tx_busy !== 1'b0) viol++;
      end
      chk("idle_tx_line", viol, 0);
      chk("idle_strobes", n_valid + n_ferr + n_clr, 0);

      // TX vectors
      for (int t = 0; t < 2; t++) begin
         tx_frame(tx_tab[t].d, tx_tab[t].f, tx_tab[t].poke);
         if (tx_tab[t].hold) begin
            viol = 0;
            repeat (500) begin
               @(negedge clock);
               if (tx_busy !== 1'b0 || ser_tx !== 1'b1) viol++;
            end
            chk("tx_hold_no_retransmit", viol, 0);
            tx_start = 1'b0;
            repeat (20000) @(negedge clock);
         end else begin
            tx_start = 1'b0;
            repeat (10) @(negedge clock);
         end
      end
      chk("tx_clear_count", n_clr, 2);

      // RX vectors: first two back-to-back
      for (int r = 0; r < 4; r++) begin
         v0 = n_valid;
         e0 = n_ferr;
         if (rx_tab[r].glitch) begin
            ser_rx = 1'b0;
            repeat (100) @(negedge clock);
            ser_rx = 1'b1;
            repeat (CPB + 50) @(negedge clock);
         end else begin
            rx_frame(rx_tab[r].b, rx_tab[r].stop, rx_tab[r].stop ? CPB : 220);
            if (!rx_tab[r].stop) repeat (CPB + 50) @(negedge clock);
         end
         chk($sformatf("rx%0d_valid_cnt", r), n_valid - v0, rx_tab[r].ev);
         chk($sformatf("rx%0d_err_cnt", r), n_ferr - e0, rx_tab[r].ee);
         chk($sformatf("rx%0d_rx_data", r), rx_data, rx_tab[r].ed);
         if (rx_tab[r].ev != 0)
            chk($sformatf("rx%0d_strobe_data", r), last_rx, rx_tab[r].ed);
      end

      // reset mid-frame during TX of 0xA5
      @(negedge clock);
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      repeat (1000) @(negedge clock);
      chk("a5_midframe_bit", ser_tx, 0);
      chk("a5_midframe_busy", tx_busy, 1);
      c0    = n_clr;
      reset = 1'b1;
      #1;
      chk("a5_rst_ser_tx", ser_tx, 1);
      chk("a5_rst_busy", tx_busy, 0);
      chk("a5_rst_clear", tx_clear_req, 0);
      tx_start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (4000) @(negedge clock);
      chk("a5_no_clear_after_rst", n_clr - c0, 0);
      chk("a5_idle_after_rst", tx_busy, 0);
      chk("a5_rx_data_cleared", rx_data, 0);

      tx_frame(8'hC3, 10'b1110000110, 1'b0);
      tx_start = 1'b0;
      repeat (10) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tb_uart_bfm.md
Name: tb_uart_bfm

Overview:
- Simple 8N1 UART transceiver used as a bench-side companion to the SoC's user UART.
- Transmitter: serialises a byte onto ser_tx when requested by the stimulus driver, with a busy/complete handshake.
- Receiver: deserialises frames arriving on ser_rx (SoC UART TX, mprj_io[6]) and presents each byte with a valid strobe.
- Both directions run from one clock and a fixed bit period; no FIFOs.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz clock, 115200 baud).
- DATA_BITS, 8, data bits per frame; fixed 8, LSB first, no parity, 1 stop bit.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ser_rx  input  1  serial input from the DUT UART TX; idle high.
- ser_tx  output  1  serial output to the DUT UART RX; idle high.
- tx_start  input  1  transmit request; level signal, rising edge launches one frame.
- tx_data  input  8  byte to send; captured on the cycle the start edge is detected.
- tx_busy  output  1  high while a TX frame is in progress.
- tx_clear_req  output  1  one-cycle pulse when a TX frame completes (stop bit finished).
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle strobe: rx_data updated with a good frame.
- rx_frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset values (asynchronous, immediate):
  - ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0, rx_valid=0, rx_frame_err=0.
  - Both FSMs return to IDLE and all counters clear.
- Reset mid-frame aborts the frame; ser_tx returns high at once. No completion pulse follows.
- tx_start handling:
  - Registered each cycle; a start edge is tx_start=1 while the previous sample was 0.
  - The start edge is the only launch condition; holding tx_start high never retransmits.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: ser_tx=1. On a start edge, latch tx_data, set tx_busy=1 the next cycle, enter START.
  - tx_busy must be high no later than 2 clocks after tx_start rises.
  - START: ser_tx=0 for CLKS_PER_BIT cycles.
  - DATA: ser_tx=latched bit i, i=0..7 (LSB first), CLKS_PER_BIT cycles each.
  - STOP: ser_tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: tx_busy->0 and tx_clear_req=1 for exactly one cycle, in the same cycle; enter IDLE.
  - Total busy time is 10*CLKS_PER_BIT cycles, +/-1.
- Start edges while tx_busy=1 are ignored and not queued.
- tx_data changes during a frame have no effect.
- RX path:
  - ser_rx passes through a 2-flop synchroniser first.
  - RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: wait for synchronised ser_rx=0.
  - START: wait CLKS_PER_BIT/2 cycles (integer division) and resample; if high, treat as a glitch and return to IDLE with no strobe.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit, shifting LSB first, 8 samples.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop=1: rx_data<=byte, rx_valid=1 for one cycle.
    - Stop=0: rx_frame_err=1 for one cycle; rx_data unchanged.
  - Return to IDLE right after the stop sample, so back-to-back frames are accepted.
- rx_data holds its value until the next good frame.
- TX and RX are fully independent; simultaneous activity is legal.

Test Plan:
- Reset, then idle: ser_tx=1, tx_busy=0, no strobes for 1000 cycles with ser_rx=1.
- tx_start rises, tx_data=0x0F:
  - tx_busy=1 within 2 cycles.
  - ser_tx = 0,1,1,1,1,0,0,0,0,1, each bit 347 cycles.
  - tx_busy falls after ~3470 cycles, with a one-cycle tx_clear_req in the same cycle.
- tx_start held high past completion: no second frame.
  - Lower it, wait 500 us, raise it with tx_data=0x3D.
  - ser_tx = 0,1,0,1,1,1,1,0,0,1.
- Drive ser_rx with a frame for 0x41 at 347 cycles/bit, then immediately a frame for 0x0A:
  - rx_valid pulses twice; rx_data=0x41, then 0x0A.
  - rx_frame_err stays 0.
- ser_rx low pulse of 100 cycles: no rx_valid or rx_frame_err; RX back in IDLE.
  - Then a frame for 0x55 with stop bit 0: rx_frame_err=1 for one cycle, rx_data unchanged.
- Assert reset mid-frame during TX of 0xA5: ser_tx=1 and tx_busy=0 immediately, no tx_clear_req.
  - After release, a new start edge sends a complete frame.
